// File: rtl/mux_fwd_hold.sv
// Purpose: N-input EX-stage operand-forwarding mux with stall hold, flush, shadow capture/replay, bad-select detection.
// Latency: 1 cycle from select/data sampled at an edge to o_Salida/o_Valid after that edge.
// Backpressure: i_Stall freezes the output register; forwarded values seen during a stall are replayed on release.
module mux_fwd_hold #(
    parameter int BUS_SIZE   = 32,
    parameter int N_INPUTS   = 4,
    localparam int SEL_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic [SEL_W-1:0]             i_Control,
    input  logic [N_INPUTS*BUS_SIZE-1:0] i_Inputs,
    input  logic                         i_Valid,
    input  logic                         i_Stall,
    input  logic                         i_Flush,
    output logic [BUS_SIZE-1:0]          o_Salida,
    output logic                         o_Valid,
    output logic                         o_Captured,
    output logic                         o_SelError,
    output logic [7:0]                   o_SelErrCount
);

    // Channel count widened by one bit so "select >= N_INPUTS" is representable
    // even when N_INPUTS is an exact power of two (the compare is then never true).
    localparam logic [SEL_W:0] N_SEL = N_INPUTS[SEL_W:0];

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Channel unpacking and select decode
    // ------------------------------------------------------------------
    logic [BUS_SIZE-1:0] ch [N_INPUTS];

    for (genvar k = 0; k < N_INPUTS; k++) begin : g_unpack
        assign ch[k] = i_Inputs[k*BUS_SIZE +: BUS_SIZE];
    end

    logic                sel_in_range;
    logic                sel_fwd;        // in range and names a forwarded channel
    logic                sel_bad;        // meaningful select that names no channel
    logic                capture_hit;    // forwarded value worth keeping in the shadow
    logic [BUS_SIZE-1:0] sel_dat;

    assign sel_in_range = ({1'b0, i_Control} < N_SEL);
    assign sel_fwd      = sel_in_range && (i_Control != '0);
    assign sel_bad      = i_Valid && !sel_in_range;
    assign capture_hit  = i_Valid && sel_fwd;

    // Out-of-range selects fall back to the register-file channel.
    always_comb begin
        sel_dat = ch[0];
        for (int k = 1; k < N_INPUTS; k++) begin
            if (i_Control == k[SEL_W-1:0]) begin
                sel_dat = ch[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage, shadow register and RUN/HOLD control
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [BUS_SIZE-1:0] salida_q;
    logic                valid_q;
    logic                captured_q;
    logic [BUS_SIZE-1:0] shadow_q;
    logic                shadow_vld_q;

    // Release-edge value: a live forward beats the shadow, the shadow beats channel 0.
    logic [BUS_SIZE-1:0] release_d;
    logic                release_cap_d;

    always_comb begin
        release_d     = ch[0];
        release_cap_d = 1'b0;
        if (sel_fwd) begin
            release_d = sel_dat;
        end else if (shadow_vld_q) begin
            release_d     = shadow_q;
            release_cap_d = 1'b1;
        end
    end

    // Priority reset > flush > stall > normal update; single FSM register block.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q      <= ST_RUN;
            salida_q     <= '0;
            valid_q      <= 1'b0;
            captured_q   <= 1'b0;
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
        end else if (i_Flush) begin
            // Bubble: clear the stage and forget any pending replay.
            state_q      <= ST_RUN;
            salida_q     <= '0;
            valid_q      <= 1'b0;
            captured_q   <= 1'b0;
            shadow_vld_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    captured_q <= 1'b0;
                    if (i_Stall) begin
                        // Entering a stall: start with an empty shadow, then
                        // catch a forward present in this very cycle.
                        state_q <= ST_HOLD;
                        if (capture_hit) begin
                            shadow_q     <= sel_dat;
                            shadow_vld_q <= 1'b1;
                        end else begin
                            shadow_vld_q <= 1'b0;
                        end
                    end else begin
                        salida_q <= sel_dat;
                        valid_q  <= i_Valid;
                    end
                end
                ST_HOLD: begin
                    if (i_Stall) begin
                        // Outputs frozen; the most recent forward seen wins.
                        captured_q <= 1'b0;
                        if (capture_hit) begin
                            shadow_q     <= sel_dat;
                            shadow_vld_q <= 1'b1;
                        end
                    end else begin
                        state_q      <= ST_RUN;
                        salida_q     <= release_d;
                        valid_q      <= i_Valid;
                        captured_q   <= release_cap_d;
                        shadow_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_RUN;
                    captured_q   <= 1'b0;
                    shadow_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bad-select monitor: sticky flag plus saturating count, unaffected
    // by stall or flush so software sees every occurrence.
    // ------------------------------------------------------------------
    logic       sel_err_q;
    logic [7:0] sel_cnt_q;

    // Sticky error flag and saturating error counter.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sel_err_q <= 1'b0;
            sel_cnt_q <= '0;
        end else if (sel_bad) begin
            sel_err_q <= 1'b1;
            if (sel_cnt_q != 8'hFF) begin
                sel_cnt_q <= sel_cnt_q + 8'd1;
            end
        end
    end

    assign o_Salida      = salida_q;
    assign o_Valid       = valid_q;
    assign o_Captured    = captured_q;
    assign o_SelError    = sel_err_q;
    assign o_SelErrCount = sel_cnt_q;

endmodule

// File: tb/tb_mux_fwd_hold.sv
// Purpose: self-checking bench for mux_fwd_hold (N=4 main instance, N=3 instance for bad selects).
// Latency: every check samples 1 time unit after the rising edge that produced the value.
// Backpressure: stall/flush driven directly; reference model tracks stall episodes abstractly.
module tb_mux_fwd_hold;

    localparam int W  = 32;
    localparam int NA = 4;
    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rst_b = 1'b1;
    logic [1:0]    ctrl = '0;
    logic          valid = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  chv [NA];
    logic [NA*W-1:0] in_bus;

    logic [W-1:0]  a_out, b_out;
    logic          a_vld, a_cap, a_err, b_vld, b_cap, b_err;
    logic [7:0]    a_cnt, b_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (N=4 instance)
    logic [W-1:0]  m_out = '0;
    logic          m_vld = 1'b0;
    logic          m_cap = 1'b0;
    logic          m_err = 1'b0;
    logic [7:0]    m_cnt = '0;
    logic          m_stalled = 1'b0;
    logic          m_have = 1'b0;
    logic [W-1:0]  m_shadow = '0;

    assign in_bus = {chv[3], chv[2], chv[1], chv[0]};

    always #5 clk = ~clk;

    mux_fwd_hold #(.BUS_SIZE(W), .N_INPUTS(NA)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Control(ctrl), .i_Inputs(in_bus),
        .i_Valid(valid), .i_Stall(stall), .i_Flush(flush),
        .o_Salida(a_out), .o_Valid(a_vld), .o_Captured(a_cap),
        .o_SelError(a_err), .o_SelErrCount(a_cnt)
    );

    mux_fwd_hold #(.BUS_SIZE(W), .N_INPUTS(NB)) dut_b (
        .i_Clock(clk), .i_Reset(rst_b), .i_Control(ctrl), .i_Inputs(in_bus[NB*W-1:0]),
        .i_Valid(valid), .i_Stall(stall), .i_Flush(flush),
        .o_Salida(b_out), .o_Valid(b_vld), .o_Captured(b_cap),
        .o_SelError(b_err), .o_SelErrCount(b_cnt)
    );

    // One clock of the reference model: a stall episode remembers the last
    // forwarded value; the first non-stalled cycle after it decides what leaves.
    task automatic model_step();
        logic         inr, live;
        logic [W-1:0] selv;
        if (rst) begin
            m_out = '0; m_vld = 0; m_cap = 0; m_err = 0; m_cnt = '0;
            m_stalled = 0; m_have = 0; m_shadow = '0;
        end else begin
            inr  = (int'(ctrl) < NA);
            live = inr && (ctrl != 0);
            selv = inr ? chv[ctrl] : chv[0];
            if (valid && !inr) begin
                m_err = 1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 1;
            end
            if (flush) begin
                m_out = '0; m_vld = 0; m_cap = 0; m_have = 0; m_stalled = 0;
            end else if (stall) begin
                m_cap = 0;
                if (!m_stalled) m_have = 0;
                m_stalled = 1;
                if (valid && live) begin
                    m_shadow = selv;
                    m_have   = 1;
                end
            end else begin
                if (m_stalled) begin
                    m_out = live ? selv : (m_have ? m_shadow : chv[0]);
                    m_cap = !live && m_have;
                end else begin
                    m_out = selv;
                    m_cap = 0;
                end
                m_vld = valid;
                m_have = 0;
                m_stalled = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_chans(input logic [W-1:0] c0, c1, c2, c3);
        chv[0] = c0; chv[1] = c1; chv[2] = c2; chv[3] = c3;
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; flush = 0; valid = 1; ctrl = 2;
        set_chans(32'h11, 32'h22, 32'h33, 32'h44);
        tick(); tick();
        n_checks++; if (a_out !== '0) $display("FAIL reset_out got %0h exp 0", a_out); else n_pass++;
        n_checks++; if (a_vld !== 1'b0) $display("FAIL reset_vld got %0b exp 0", a_vld); else n_pass++;
        n_checks++; if (a_cap !== 1'b0) $display("FAIL reset_cap got %0b exp 0", a_cap); else n_pass++;
        n_checks++; if (a_err !== 1'b0) $display("FAIL reset_err got %0b exp 0", a_err); else n_pass++;
        n_checks++; if (a_cnt !== 8'd0) $display("FAIL reset_cnt got %0d exp 0", a_cnt); else n_pass++;
        rst = 0;
    endtask

    task automatic test_basic();
        set_chans(32'd10, 32'd20, 32'd30, 32'd40);
        ctrl = 2; valid = 1; stall = 0; flush = 0;
        tick();
        n_checks++; if (a_out !== 32'd30) $display("FAIL basic_out got %0d exp 30", a_out); else n_pass++;
        n_checks++; if (a_vld !== 1'b1) $display("FAIL basic_vld got %0b exp 1", a_vld); else n_pass++;
        n_checks++; if (a_cap !== 1'b0) $display("FAIL basic_cap got %0b exp 0", a_cap); else n_pass++;
        ctrl = 3; valid = 0;
        tick();
        n_checks++; if (a_out !== 32'd40) $display("FAIL basic_out3 got %0d exp 40", a_out); else n_pass++;
        n_checks++; if (a_vld !== 1'b0) $display("FAIL basic_vld0 got %0b exp 0", a_vld); else n_pass++;
        ctrl = 2; valid = 1;
        tick();
    endtask

    // Three stall cycles, forward seen in cycle 2, released with the given select.
    task automatic stall_capture(input logic [1:0] rel_ctrl);
        set_chans(32'd10, 32'hAB, 32'd30, 32'h55);
        valid = 1; stall = 1; ctrl = 0;
        tick();
        ctrl = 1; tick();
        ctrl = 0; tick();
        n_checks++; if (a_out !== 32'd30) $display("FAIL hold_out got %0h exp 1e", a_out); else n_pass++;
        stall = 0; ctrl = rel_ctrl;
        tick();
    endtask

    task automatic test_capture_replay();
        stall_capture(2'd0);
        n_checks++; if (a_out !== 32'hAB) $display("FAIL replay_out got %0h exp ab", a_out); else n_pass++;
        n_checks++; if (a_cap !== 1'b1) $display("FAIL replay_cap got %0b exp 1", a_cap); else n_pass++;
        n_checks++; if (a_vld !== 1'b1) $display("FAIL replay_vld got %0b exp 1", a_vld); else n_pass++;
        ctrl = 2; tick();
        n_checks++; if (a_cap !== 1'b0) $display("FAIL replay_pulse got %0b exp 0", a_cap); else n_pass++;
        n_checks++; if (a_out !== 32'd30) $display("FAIL replay_next got %0h exp 1e", a_out); else n_pass++;
    endtask

    task automatic test_live_wins();
        stall_capture(2'd3);
        n_checks++; if (a_out !== 32'h55) $display("FAIL live_out got %0h exp 55", a_out); else n_pass++;
        n_checks++; if (a_cap !== 1'b0) $display("FAIL live_cap got %0b exp 0", a_cap); else n_pass++;
    endtask

    task automatic test_flush_stall();
        set_chans(32'd10, 32'hAB, 32'd30, 32'h55);
        valid = 1; stall = 1; ctrl = 0; tick();
        ctrl = 1; tick();
        flush = 1; tick();
        n_checks++; if (a_out !== '0) $display("FAIL flush_out got %0h exp 0", a_out); else n_pass++;
        n_checks++; if (a_vld !== 1'b0) $display("FAIL flush_vld got %0b exp 0", a_vld); else n_pass++;
        flush = 0; stall = 0; ctrl = 0; tick();
        n_checks++; if (a_out !== 32'd10) $display("FAIL flush_next got %0h exp a", a_out); else n_pass++;
        n_checks++; if (a_cap !== 1'b0) $display("FAIL flush_cap got %0b exp 0", a_cap); else n_pass++;
        n_checks++; if (a_vld !== 1'b1) $display("FAIL flush_vld1 got %0b exp 1", a_vld); else n_pass++;
    endtask

    task automatic test_back_to_back();
        set_chans(32'd10, 32'hAB, 32'd30, 32'h55);
        valid = 1; stall = 1; ctrl = 1; tick();
        stall = 0; ctrl = 0; tick();
        n_checks++; if (a_out !== 32'hAB) $display("FAIL b2b_first got %0h exp ab", a_out); else n_pass++;
        stall = 1; ctrl = 0; tick();
        stall = 0; tick();
        n_checks++; if (a_out !== 32'd10) $display("FAIL b2b_second got %0h exp a", a_out); else n_pass++;
        n_checks++; if (a_cap !== 1'b0) $display("FAIL b2b_cap got %0b exp 0", a_cap); else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        set_chans(32'd10, 32'hAB, 32'd30, 32'h55);
        valid = 1; stall = 1; ctrl = 1; tick();
        tick();
        rst = 1; tick();
        n_checks++; if (a_out !== '0) $display("FAIL rsthold_out got %0h exp 0", a_out); else n_pass++;
        n_checks++; if (a_vld !== 1'b0) $display("FAIL rsthold_vld got %0b exp 0", a_vld); else n_pass++;
        n_checks++; if (a_cap !== 1'b0) $display("FAIL rsthold_cap got %0b exp 0", a_cap); else n_pass++;
        rst = 0; stall = 1; ctrl = 0; tick();
        stall = 0; tick();
        n_checks++; if (a_out !== 32'd10) $display("FAIL rsthold_rel got %0h exp a", a_out); else n_pass++;
        n_checks++; if (a_cap !== 1'b0) $display("FAIL rsthold_relcap got %0b exp 0", a_cap); else n_pass++;
    endtask

    task automatic test_bad_select();
        set_chans(32'd10, 32'd20, 32'd30, 32'd40);
        rst_b = 1; valid = 1; stall = 0; flush = 0; ctrl = 0; tick();
        rst_b = 0; ctrl = 3; tick();
        n_checks++; if (b_cnt !== 8'd1) $display("FAIL badsel_cnt1 got %0d exp 1", b_cnt); else n_pass++;
        n_checks++; if (b_err !== 1'b1) $display("FAIL badsel_err1 got %0b exp 1", b_err); else n_pass++;
        for (int i = 1; i < 300; i++) tick();
        n_checks++; if (b_out !== 32'd10) $display("FAIL badsel_out got %0d exp 10", b_out); else n_pass++;
        n_checks++; if (b_err !== 1'b1) $display("FAIL badsel_err got %0b exp 1", b_err); else n_pass++;
        n_checks++; if (b_cnt !== 8'hFF) $display("FAIL badsel_cnt got %0d exp 255", b_cnt); else n_pass++;
        n_checks++; if (a_out !== 32'd40) $display("FAIL badsel_a_out got %0d exp 40", a_out); else n_pass++;
        n_checks++; if (a_err !== 1'b0) $display("FAIL badsel_a_err got %0b exp 0", a_err); else n_pass++;
        // Flush and stall must not clear the sticky state
        flush = 1; stall = 1; tick();
        n_checks++; if (b_err !== 1'b1) $display("FAIL badsel_flush_err got %0b exp 1", b_err); else n_pass++;
        n_checks++; if (b_cnt !== 8'hFF) $display("FAIL badsel_flush_cnt got %0d exp 255", b_cnt); else n_pass++;
        flush = 0; stall = 0; ctrl = 0; tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 19) == 0);
            stall = ($urandom_range(0, 9) < 4);
            valid = ($urandom_range(0, 3) != 0);
            ctrl  = 2'($urandom_range(0, 3));
            for (int k = 0; k < NA; k++) chv[k] = $urandom;
            tick();
            n_checks++; if (a_out !== m_out) $display("FAIL rnd_out cyc %0d got %0h exp %0h", i, a_out, m_out); else n_pass++;
            n_checks++; if (a_vld !== m_vld) $display("FAIL rnd_vld cyc %0d got %0b exp %0b", i, a_vld, m_vld); else n_pass++;
            n_checks++; if (a_cap !== m_cap) $display("FAIL rnd_cap cyc %0d got %0b exp %0b", i, a_cap, m_cap); else n_pass++;
            n_checks++; if (a_err !== m_err) $display("FAIL rnd_err cyc %0d got %0b exp %0b", i, a_err, m_err); else n_pass++;
            n_checks++; if (a_cnt !== m_cnt) $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", i, a_cnt, m_cnt); else n_pass++;
        end
        rst = 0; flush = 0; stall = 0;
    endtask

    initial begin
        set_chans('0, '0, '0, '0);
        test_reset();
        test_basic();
        test_capture_replay();
        test_live_wins();
        test_flush_stall();
        test_back_to_back();
        test_reset_mid_hold();
        test_bad_select();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
